// File: rtl/cmd_ram_pkg.sv
// Shared types for the command-decoded burst RAM: opcodes, FSM states and
// a width helper used to size the command payload.
package cmd_ram_pkg;

  typedef enum logic [1:0] {
    OP_WR_ADDR  = 2'b00,
    OP_WR_DATA  = 2'b01,
    OP_RD_ADDR  = 2'b10,
    OP_RD_BURST = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    TX    = 2'b10
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cmd_ram_mem.sv
// Single-port storage: synchronous write, asynchronous read.
// CMD_RAM_BURST_PARITY_EN adds an even-parity bit per word and a read-side check.
module cmd_ram_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
`ifdef CMD_RAM_BURST_PARITY_EN
  ,
  output logic              rd_par_bad_o
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef CMD_RAM_BURST_PARITY_EN
  logic [DATA_W:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= {^wdata_i, wdata_i};
  end

  assign rdata_o = mem_q[raddr_i][DATA_W-1:0];
  // Data plus stored parity must XOR to zero for an intact word.
  assign rd_par_bad_o = ^mem_q[raddr_i];
`else
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
`endif

endmodule

// File: rtl/cmd_ram_burst.sv
// Command decoder, address pointers, burst counter and read FSM around cmd_ram_mem.
// Optional parity checking is enabled by CMD_RAM_BURST_PARITY_EN.
//   state | meaning
//   IDLE  | accepting command words
//   FETCH | first burst word being loaded into tx_data
//   TX    | tx_data valid, waiting on tx_ready
module cmd_ram_burst
  import cmd_ram_pkg::*;
#(
  parameter  int ADDR_W   = 8,
  parameter  int DATA_W   = 8,
  parameter  int BURST_W  = 4,
  parameter  int AUTO_INC = 1,
  localparam int PAY_W    = max3(ADDR_W, DATA_W, BURST_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PAY_W+1:0]   rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [DATA_W-1:0]  tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               par_err
);

  state_e              state_q;
  logic [ADDR_W-1:0]   wr_addr_q, rd_addr_q;
  logic [ADDR_W-1:0]   wr_addr_d, rd_addr_d;
  logic [BURST_W-1:0]  cnt_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic                tx_valid_q;
  logic [DATA_W-1:0]   rd_word;
  opcode_e             op;
  logic                accept, mem_we, load_word;

  assign rx_ready  = (state_q == IDLE);
  assign accept    = rx_valid && rx_ready;
  assign op        = opcode_e'(rx_data[PAY_W+1 -: 2]);
  assign mem_we    = accept && (op == OP_WR_DATA);
  assign wr_addr_d = wr_addr_q + ADDR_W'(AUTO_INC != 0);
  assign rd_addr_d = rd_addr_q + ADDR_W'(AUTO_INC != 0);
  assign load_word = (state_q == FETCH) ||
                     ((state_q == TX) && tx_ready && (cnt_q != '0));

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

`ifdef CMD_RAM_BURST_PARITY_EN
  logic rd_par_bad;
  logic par_err_q;

  cmd_ram_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk_i        (clk),
    .we_i         (mem_we),
    .waddr_i      (wr_addr_q),
    .wdata_i      (rx_data[DATA_W-1:0]),
    .raddr_i      (rd_addr_q),
    .rdata_o      (rd_word),
    .rd_par_bad_o (rd_par_bad)
  );

  // Sticky: the word is still delivered, only the flag records the fault.
  always_ff @(posedge clk) begin
    if (!rst_n)                       par_err_q <= 1'b0;
    else if (load_word && rd_par_bad) par_err_q <= 1'b1;
  end

  assign par_err = par_err_q;
`else
  cmd_ram_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (wr_addr_q),
    .wdata_i (rx_data[DATA_W-1:0]),
    .raddr_i (rd_addr_q),
    .rdata_o (rd_word)
  );

  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      if (load_word) begin
        tx_data_q <= rd_word;
        rd_addr_q <= rd_addr_d;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_WR_ADDR:  wr_addr_q <= rx_data[ADDR_W-1:0];
              OP_WR_DATA:  wr_addr_q <= wr_addr_d;
              OP_RD_ADDR:  rd_addr_q <= rx_data[ADDR_W-1:0];
              OP_RD_BURST: begin
                cnt_q   <= rx_data[BURST_W-1:0];
                state_q <= FETCH;
              end
              default: ;
            endcase
          end
        end
        FETCH: begin
          tx_valid_q <= 1'b1;
          state_q    <= TX;
        end
        TX: begin
          if (tx_ready) begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - BURST_W'(1);
            end else begin
              tx_valid_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_ram_burst.sv
// Randomized self-checking bench for cmd_ram_burst: one AUTO_INC=1 and one
// AUTO_INC=0 instance, checked against an array/pointer reference model.
module tb_cmd_ram_burst;
  import cmd_ram_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid, tx_ready;
  bit         sel;

  logic       rx_valid_a, rx_valid_b, tx_ready_a, tx_ready_b;
  logic       rx_ready_a, rx_ready_b, tx_valid_a, tx_valid_b;
  logic       par_err_a, par_err_b;
  logic [7:0] tx_data_a, tx_data_b;

  logic       rx_ready_s, tx_valid_s;
  logic [7:0] tx_data_s;

  int tests = 0;
  int fails = 0;

  logic [7:0] m_mem [2][256];
  logic [7:0] m_wr  [2];
  logic [7:0] m_rd  [2];

  always #5 clk = ~clk;

  assign rx_valid_a = rx_valid & ~sel;
  assign rx_valid_b = rx_valid &  sel;
  assign tx_ready_a = tx_ready & ~sel;
  assign tx_ready_b = tx_ready &  sel;
  assign rx_ready_s = sel ? rx_ready_b : rx_ready_a;
  assign tx_valid_s = sel ? tx_valid_b : tx_valid_a;
  assign tx_data_s  = sel ? tx_data_b  : tx_data_a;

  cmd_ram_burst #(.ADDR_W(8), .DATA_W(8), .BURST_W(4), .AUTO_INC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid_a),
    .rx_ready(rx_ready_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .par_err(par_err_a)
  );

  cmd_ram_burst #(.ADDR_W(8), .DATA_W(8), .BURST_W(4), .AUTO_INC(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid_b),
    .rx_ready(rx_ready_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .par_err(par_err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s (inst %0d): got %0h expected %0h at %0t", tag, sel, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] pay);
    int n = 0;
    while (!rx_ready_s && n < 50) begin
      tick;
      n++;
    end
    check("rx_ready_idle", rx_ready_s, 1);
    rx_data  = {op, pay};
    rx_valid = 1'b1;
    tick;
    rx_valid = 1'b0;
    case (op)
      OP_WR_ADDR: m_wr[sel] = pay;
      OP_WR_DATA: begin
        m_mem[sel][m_wr[sel]] = pay;
        if (sel == 1'b0) m_wr[sel] = m_wr[sel] + 8'd1;
      end
      OP_RD_ADDR: m_rd[sel] = pay;
      default: ;
    endcase
  endtask

  // mode 0: always ready; 1: random stalls; 2: stall the first word 3 cycles
  task automatic burst(input logic [3:0] len, input int mode);
    logic [7:0] exp_q[$];
    logic [7:0] a;
    int         stalls;
    bit         r;
    for (int i = 0; i <= int'(len); i++) begin
      a = (sel == 1'b0) ? m_rd[sel] + 8'(i) : m_rd[sel];
      exp_q.push_back(m_mem[sel][a]);
    end
    if (sel == 1'b0) m_rd[sel] = m_rd[sel] + 8'(len) + 8'd1;
    send(OP_RD_BURST, {4'($urandom), len});
    check("fetch_tx_valid", tx_valid_s, 0);
    check("fetch_rx_ready", rx_ready_s, 0);
    tx_ready = 1'($urandom);
    tick;
    for (int k = 0; k <= int'(len); k++) begin
      stalls = 0;
      while (1) begin
        check("tx_valid", tx_valid_s, 1);
        check("tx_data", tx_data_s, exp_q[k]);
        check("busy_rx_ready", rx_ready_s, 0);
        case (mode)
          0:       r = 1'b1;
          1:       r = ($urandom_range(0, 1) == 1) || (stalls >= 6);
          default: r = (k > 0) || (stalls >= 3);
        endcase
        tx_ready = r;
        tick;
        if (r) break;
        stalls++;
      end
    end
    tx_ready = 1'b0;
    check("end_tx_valid", tx_valid_s, 0);
    check("end_rx_ready", rx_ready_s, 1);
    check("end_data_held", tx_data_s, exp_q[len]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    sel      = 1'b0;
    tick;
    tick;
    check("rst_tx_valid_a", tx_valid_a, 0);
    check("rst_tx_data_a",  tx_data_a,  0);
    check("rst_rx_ready_a", rx_ready_a, 1);
    check("rst_par_err_a",  par_err_a,  0);
    check("rst_tx_valid_b", tx_valid_b, 0);
    check("rst_rx_ready_b", rx_ready_b, 1);
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      m_wr[s] = 8'h00;
      m_rd[s] = 8'h00;
    end

    sel = 1'b0;
    send(OP_WR_ADDR, 8'h00);
    for (int i = 0; i < 256; i++) send(OP_WR_DATA, 8'($urandom));
    sel = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send(OP_WR_ADDR, 8'(i));
      send(OP_WR_DATA, 8'($urandom));
    end

    // Write then two-word read, always ready
    sel = 1'b0;
    send(OP_WR_ADDR, 8'h10);
    send(OP_WR_DATA, 8'hA5);
    send(OP_WR_DATA, 8'h5A);
    send(OP_RD_ADDR, 8'h10);
    burst(4'd1, 0);
    check("model_a5", m_mem[0][8'h10], 8'hA5);

    // Backpressure on a single-word burst
    send(OP_RD_ADDR, 8'h11);
    burst(4'd0, 2);

    // Pointer wrap
    send(OP_WR_ADDR, 8'hFF);
    send(OP_WR_DATA, 8'h11);
    send(OP_WR_DATA, 8'h22);
    send(OP_RD_ADDR, 8'h00);
    burst(4'd0, 0);
    send(OP_RD_ADDR, 8'hFF);
    burst(4'd1, 1);

    // Non-incrementing instance
    sel = 1'b1;
    send(OP_WR_ADDR, 8'h05);
    send(OP_WR_DATA, 8'h33);
    send(OP_WR_DATA, 8'h44);
    send(OP_RD_ADDR, 8'h05);
    burst(4'd3, 0);

    // Reset in the middle of a 16-word burst
    sel = 1'b0;
    send(OP_RD_ADDR, 8'h20);
    send(OP_RD_BURST, 8'h0F);
    tx_ready = 1'b1;
    tick;
    tick;
    check("midburst_valid", tx_valid_s, 1);
    rst_n = 1'b0;
    tick;
    check("rst_mid_tx_valid", tx_valid_s, 0);
    check("rst_mid_rx_ready", rx_ready_s, 1);
    check("rst_mid_tx_data",  tx_data_s,  0);
    rst_n    = 1'b1;
    tx_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      m_wr[s] = 8'h00;
      m_rd[s] = 8'h00;
    end
    burst(4'd2, 1);
    send(OP_WR_DATA, 8'hC3);
    send(OP_RD_ADDR, 8'h00);
    burst(4'd0, 0);
    sel = 1'b1;
    burst(4'd0, 0);

    // Random command mix over both instances
    for (int n = 0; n < 80; n++) begin
      logic [1:0] op;
      sel = 1'($urandom);
      op  = 2'($urandom);
      if (op == OP_RD_BURST) burst(4'($urandom), 1);
      else                   send(op, 8'($urandom));
    end

    check("par_err_a_clear", par_err_a, 0);
    check("par_err_b_clear", par_err_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
